// File: rtl/adc_avg_seq.sv
// Purpose: ADC conversion sequencer with 2^AVG_LOG2 sample averaging and a sticky overrun flag.
// Latency: start pulse one cycle after the tick; average on data_o one cycle after the last ready strobe.
// Backpressure: single output register; a new average arriving while it is held is dropped and flagged.
module adc_avg_seq #(
    parameter int RESOLUTION = 4,
    parameter int AVG_LOG2   = 2,
    parameter int PERIOD_W   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [PERIOD_W-1:0]   period_i,
    input  logic                  clr_ovr_i,
    output logic                  adc_start_o,
    input  logic                  adc_rdy_i,
    input  logic [RESOLUTION-1:0] adc_data_i,
    output logic [RESOLUTION-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overrun_o
);

    localparam int ACC_W = RESOLUTION + AVG_LOG2;
    // Pass-through still needs a one-bit counter; it simply never leaves zero.
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;

    logic [1:0]            r_state;
    logic [PERIOD_W-1:0]   r_timer;
    logic [ACC_W-1:0]      r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_start;
    logic [RESOLUTION-1:0] r_data;
    logic                  r_valid;
    logic                  r_ovr;

    logic [1:0]            w_state_nxt;
    logic                  w_tick;
    logic                  w_rdy_acc;
    logic [ACC_W-1:0]      w_acc_next;
    logic                  w_last;
    logic                  w_avg_vld;
    logic [RESOLUTION-1:0] w_avg;
    logic                  w_out_free;
    logic                  w_ovr_set;

    assign w_tick     = (r_state != S_OFF) && (r_timer == '0);
    // Strobes outside a conversion are stray and must not touch the accumulator.
    assign w_rdy_acc  = (r_state == S_BUSY) && adc_rdy_i;
    assign w_acc_next = r_acc + ACC_W'(adc_data_i);
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_avg_vld  = w_rdy_acc && w_last;
    // Truncating mean: drop the AVG_LOG2 LSBs of the completed sum.
    assign w_avg      = w_acc_next[ACC_W-1:AVG_LOG2];
    assign w_out_free = !r_valid || ready_i;
    assign w_ovr_set  = (w_tick && (r_state == S_BUSY)) || (w_avg_vld && !w_out_free);

    // Next-state selection; disable wins over a coinciding tick in ARMED,
    // while BUSY always waits for the in-flight result.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_OFF: begin
                if (en_i) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (!en_i)       w_state_nxt = S_OFF;
                else if (w_tick) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (adc_rdy_i) w_state_nxt = en_i ? S_ARMED : S_OFF;
            end
            default: w_state_nxt = S_OFF;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_OFF;
        else       r_state <= w_state_nxt;
    end

    // Trigger timer: parked at period_i while off, reloads on every tick.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                  r_timer <= '0;
        else if (r_state == S_OFF)  r_timer <= period_i;
        else if (w_tick)            r_timer <= period_i;
        else                        r_timer <= r_timer - PERIOD_W'(1);
    end

    // One-cycle start pulse issued only for the ARMED -> BUSY transition.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_start <= 1'b0;
        else       r_start <= (r_state == S_ARMED) && (w_state_nxt == S_BUSY);
    end

    // Accumulator and sample count; anything heading to OFF discards the partial group.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_state_nxt == S_OFF) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_rdy_acc) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Output register: load when free (empty or being consumed), else hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_avg_vld && w_out_free) begin
            r_data  <= w_avg;
            r_valid <= 1'b1;
        end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky overrun; a set event in the same cycle as a clear keeps it high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          r_ovr <= 1'b0;
        else if (w_ovr_set) r_ovr <= 1'b1;
        else if (clr_ovr_i) r_ovr <= 1'b0;
    end

    assign adc_start_o = r_start;
    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign overrun_o   = r_ovr;

endmodule

// File: tb/tb_adc_avg_seq.sv
// Bench for adc_avg_seq: a 4-sample averaging instance driven through vector tables
// and corner sequences, plus a pass-through instance running alongside.
// Both ADC models answer each start with a ready strobe 10 cycles after the start cycle.
`timescale 1ns/1ps
module tb_adc_avg_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // averaging instance (AVG_LOG2 = 2)
    logic        rst, en, clr, ready, adc_rdy;
    logic [15:0] period;
    logic [3:0]  adc_data;
    logic        adc_start, valid, ovr;
    logic [3:0]  data;

    // pass-through instance (AVG_LOG2 = 0)
    logic        pt_rst, pt_en, pt_clr, pt_ready, pt_rdy;
    logic [15:0] pt_period;
    logic [3:0]  pt_adc_data;
    logic        pt_start, pt_valid, pt_ovr;
    logic [3:0]  pt_data;

    adc_avg_seq #(.RESOLUTION(4), .AVG_LOG2(2), .PERIOD_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .period_i(period), .clr_ovr_i(clr),
        .adc_start_o(adc_start), .adc_rdy_i(adc_rdy), .adc_data_i(adc_data),
        .data_o(data), .valid_o(valid), .ready_i(ready), .overrun_o(ovr)
    );

    adc_avg_seq #(.RESOLUTION(4), .AVG_LOG2(0), .PERIOD_W(16)) pt (
        .clk_i(clk), .rst_i(pt_rst), .en_i(pt_en), .period_i(pt_period), .clr_ovr_i(pt_clr),
        .adc_start_o(pt_start), .adc_rdy_i(pt_rdy), .adc_data_i(pt_adc_data),
        .data_o(pt_data), .valid_o(pt_valid), .ready_i(pt_ready), .overrun_o(pt_ovr)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cd = 0;
    int pt_cd = 0;
    int rdy_total = 0;
    int feed[$];
    int start_log[$];
    int pt_start_log[$];
    int base;
    int nstarts;
    int valid_cyc;

    typedef struct packed {
        logic [3:0] s0, s1, s2, s3;
        logic [3:0] avg;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle, then update both ADC models in the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (pt_rdy) begin
            chk("pt_valid_after_rdy", int'(pt_valid), 1);
            chk("pt_data", int'(pt_data), 9);
        end
        adc_rdy  = 1'b0;
        adc_data = 4'd0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                adc_rdy = 1'b1;
                if (feed.size() > 0) adc_data = 4'(feed.pop_front());
                rdy_total++;
            end
        end
        if (adc_start) begin
            cd = 10;
            start_log.push_back(cyc);
        end
        pt_rdy = 1'b0;
        if (pt_cd > 0) begin
            pt_cd--;
            if (pt_cd == 0) pt_rdy = 1'b1;
        end
        if (pt_start) begin
            pt_cd = 10;
            pt_start_log.push_back(cyc);
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int b = 0;
        while (!valid && b < budget) begin
            step();
            b++;
        end
        chk(name, int'(valid), 1);
    endtask

    task automatic wait_rdys(input string name, input int n);
        int b = 0;
        while (rdy_total < n && b < 400) begin
            step();
            b++;
        end
        chk(name, int'(rdy_total >= n), 1);
    endtask

    task automatic wait_start(input string name);
        int b = 0;
        while (!adc_start && b < 60) begin
            step();
            b++;
        end
        chk(name, int'(adc_start), 1);
    endtask

    initial begin
        vecs[0] = '{4'd3,  4'd4,  4'd5,  4'd7,  4'd4};
        vecs[1] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
        vecs[2] = '{4'd0,  4'd0,  4'd0,  4'd1,  4'd0};
        vecs[3] = '{4'd1,  4'd2,  4'd3,  4'd5,  4'd2};
        vecs[4] = '{4'd8,  4'd8,  4'd8,  4'd9,  4'd8};
        vecs[5] = '{4'd15, 4'd14, 4'd15, 4'd15, 4'd14};

        rst = 1'b1; en = 1'b0; clr = 1'b0; ready = 1'b1; period = 16'd20;
        adc_rdy = 1'b0; adc_data = 4'd0;
        pt_rst = 1'b1; pt_en = 1'b0; pt_clr = 1'b0; pt_ready = 1'b1; pt_period = 16'd20;
        pt_rdy = 1'b0; pt_adc_data = 4'd9;

        repeat (3) step();
        chk("rst_start", int'(adc_start), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_ovr", int'(ovr), 0);
        chk("rst_pt_valid", int'(pt_valid), 0);

        // cycle 0: reset released, both instances enabled
        rst = 1'b0; pt_rst = 1'b0;
        en = 1'b1; pt_en = 1'b1;
        cyc = 0;
        start_log.delete();
        pt_start_log.delete();
        foreach (vecs[i]) begin
            feed.push_back(int'(vecs[i].s0));
            feed.push_back(int'(vecs[i].s1));
            feed.push_back(int'(vecs[i].s2));
            feed.push_back(int'(vecs[i].s3));
        end

        // table-driven averaging, ready held high
        for (int i = 0; i < 6; i++) begin
            wait_valid($sformatf("vec%0d_valid", i), 150);
            chk($sformatf("vec%0d_avg", i), int'(data), int'(vecs[i].avg));
            valid_cyc = cyc;
            if (i == 0) chk("first_valid_cycle", valid_cyc, 96);
            step();
            if (i == 0) chk("valid_clears_on_handshake", int'(valid), 0);
        end
        chk("first_start_cycle", start_log[0], 22);
        chk("start_spacing", start_log[1] - start_log[0], 21);
        chk("pt_first_start_cycle", pt_start_log[0], 22);
        chk("pt_start_spacing", pt_start_log[2] - pt_start_log[1], 21);
        chk("no_ovr_normal", int'(ovr), 0);

        // backpressure: second average dropped, third loads on same-cycle handshake
        feed.push_back(1); feed.push_back(1); feed.push_back(1); feed.push_back(1);
        feed.push_back(6); feed.push_back(6); feed.push_back(6); feed.push_back(6);
        feed.push_back(10); feed.push_back(10); feed.push_back(10); feed.push_back(10);
        base = rdy_total;
        ready = 1'b0;
        wait_valid("bp_first_valid", 150);
        chk("bp_first_avg", int'(data), 1);
        wait_rdys("bp_second_group", base + 8);
        step();
        chk("bp_hold_data", int'(data), 1);
        chk("bp_hold_valid", int'(valid), 1);
        chk("bp_drop_ovr", int'(ovr), 1);
        wait_rdys("bp_third_group", base + 12);
        ready = 1'b1;
        step();
        chk("bp_new_data", int'(data), 10);
        chk("bp_valid_stays", int'(valid), 1);
        step();
        chk("bp_valid_done", int'(valid), 0);

        // tick overrun at period 5; clear held high to check set-wins priority
        en = 1'b0;
        repeat (25) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_ovr_before_run", int'(ovr), 0);
        period = 16'd5;
        en = 1'b1;
        clr = 1'b1;
        start_log.delete();
        for (int b = 0; b < 60 && start_log.size() < 2; b++) step();
        chk("ovr_two_starts", int'(start_log.size() >= 2), 1);
        repeat (6) step();
        chk("ovr_set_beats_clr", int'(ovr), 1);
        step();
        chk("ovr_clr_next", int'(ovr), 0);
        clr = 1'b0;
        repeat (20) step();
        chk("ovr_sticky", int'(ovr), 1);
        chk("ovr_start_spacing", start_log[1] - start_log[0], 12);
        chk("ovr_start_spacing2", start_log[2] - start_log[1], 12);
        en = 1'b0;
        repeat (25) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("ovr_cleared", int'(ovr), 0);

        // disable after two samples while the third is in flight
        period = 16'd20;
        feed.delete();
        feed.push_back(2); feed.push_back(2); feed.push_back(9);
        base = rdy_total;
        en = 1'b1;
        wait_rdys("dis_two_samples", base + 2);
        wait_start("dis_third_start");
        en = 1'b0;
        wait_rdys("dis_inflight_rdy", base + 3);
        step();
        chk("dis_state_off", int'(dut.r_state), 0);
        chk("dis_acc_cleared", int'(dut.r_acc), 0);
        chk("dis_cnt_cleared", int'(dut.r_cnt), 0);
        chk("dis_no_valid", int'(valid), 0);
        nstarts = start_log.size();
        repeat (30) step();
        chk("dis_no_starts", start_log.size(), nstarts);
        chk("dis_still_no_valid", int'(valid), 0);
        feed.push_back(5); feed.push_back(6); feed.push_back(7); feed.push_back(8);
        en = 1'b1;
        wait_valid("reen_valid", 150);
        chk("reen_fresh_avg", int'(data), 6);
        step();

        // async reset while BUSY with an unconsumed average
        ready = 1'b0;
        feed.push_back(15); feed.push_back(15); feed.push_back(15); feed.push_back(15);
        feed.push_back(3);
        wait_valid("ar_valid", 150);
        chk("ar_avg", int'(data), 15);
        wait_start("ar_busy_start");
        repeat (2) step();
        rst = 1'b1;
        en = 1'b0;
        #2;
        chk("ar_data_zero", int'(data), 0);
        chk("ar_valid_zero", int'(valid), 0);
        chk("ar_start_zero", int'(adc_start), 0);
        chk("ar_state_off", int'(dut.r_state), 0);
        step();
        rst = 1'b0;
        for (int b = 0; b < 20 && !adc_rdy; b++) step();
        chk("ar_stray_rdy_seen", int'(adc_rdy), 1);
        step();
        chk("ar_stray_acc", int'(dut.r_acc), 0);
        chk("ar_stray_cnt", int'(dut.r_cnt), 0);
        chk("ar_stray_valid", int'(valid), 0);
        chk("ar_stray_data", int'(data), 0);

        // pass-through instance ran throughout with ready high
        chk("pt_no_ovr", int'(pt_ovr), 0);
        chk("pt_late_spacing",
            pt_start_log[pt_start_log.size()-1] - pt_start_log[pt_start_log.size()-2], 21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
